// File: rtl/alu_program_sequencer.sv
// Runs a stored program of up to 16 instructions through the 4-bit Decode_And_Execute
// ALU, writing each result back to a 4-entry register file. One instruction every two cycles.
module alu_program_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [8:0] prog_data,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [3:0] reg_data,
    input  logic       start,
    input  logic [4:0] len,
    input  logic [1:0] view_addr,
    output logic [3:0] view_data,
    output logic       busy,
    output logic       done,
    output logic [3:0] pc,
    output logic [3:0] result
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

    state_t     state;
    logic [8:0] imem [16];
    logic [3:0] regs [4];
    logic [8:0] ir;
    logic [4:0] len_c;

    logic [2:0] op;
    logic [1:0] rs_idx, rt_idx, rd_idx;
    logic [3:0] rs_val, rt_val, alu_out;
    logic       last_instr;

    assign op     = ir[8:6];
    assign rs_idx = ir[5:4];
    assign rt_idx = ir[3:2];
    assign rd_idx = ir[1:0];
    assign rs_val = regs[rs_idx];
    assign rt_val = regs[rt_idx];

    assign view_data  = regs[view_addr];
    assign last_instr = ({1'b0, pc} == (len_c - 5'd1));

    always_comb begin
        // NOTE: default first so every path assigns alu_out and no latch is inferred.
        alu_out = 4'd0;
        case (op)
            3'd0: alu_out = rs_val - rt_val;
            3'd1: alu_out = rs_val + rt_val;
            3'd2: alu_out = rs_val | rt_val;
            3'd3: alu_out = rs_val & rt_val;
            3'd4: alu_out = {rt_val[3], rt_val[3:1]};
            3'd5: alu_out = {rs_val[2:0], rs_val[3]};
            3'd6: alu_out = 4'b1010 | {3'b000, (rs_val < rt_val)};
            3'd7: alu_out = 4'b1110 | {3'b000, (rs_val == rt_val)};
            default: alu_out = 4'd0;
        endcase
    end

    // Operands are read combinationally from the pre-edge register file, so rd aliasing
    // rs/rt naturally sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            pc     <= 4'd0;
            result <= 4'd0;
            ir     <= 9'd0;
            len_c  <= 5'd0;
            // NOTE: the memories are deliberately cleared on reset; the design requires a known-zero program and register file.
            for (int i = 0; i < 16; i++) imem[i] <= 9'd0;
            for (int i = 0; i < 4; i++)  regs[i] <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (prog_we) imem[prog_addr] <= prog_data;
                    if (reg_we)  regs[reg_addr]  <= reg_data;
                    if (start) begin
                        len_c <= (len > 5'd16) ? 5'd16 : len;
                        pc    <= 4'd0;
                        if (len == 5'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    ir    <= imem[pc];
                    state <= EXEC;
                end
                EXEC: begin
                    regs[rd_idx] <= alu_out;
                    result       <= alu_out;
                    if (last_instr) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        pc    <= pc + 4'd1;
                        state <= FETCH;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Scoreboard bench: stimulus pushes the expected end-of-run state, a monitor checks it
// on every done pulse (cycle, result, pc and the whole register file).
module tb_alu_program_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [8:0] prog_data;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [3:0] reg_data;
    logic       start;
    logic [4:0] len;
    logic [1:0] view_addr;
    logic [3:0] view_data;
    logic       busy;
    logic       done;
    logic [3:0] pc;
    logic [3:0] result;

    alu_program_sequencer dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
        .start(start), .len(len),
        .view_addr(view_addr), .view_data(view_data),
        .busy(busy), .done(done), .pc(pc), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              done_cyc;
        logic [3:0]      result;
        logic [3:0]      pc;
        logic [3:0][3:0] regs;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] res, input logic [3:0] p,
                                input logic [3:0] r0, input logic [3:0] r1,
                                input logic [3:0] r2, input logic [3:0] r3);
        exp_t e;
        e.done_cyc = 0;
        e.result   = res;
        e.pc       = p;
        e.regs[0]  = r0;
        e.regs[1]  = r1;
        e.regs[2]  = r2;
        e.regs[3]  = r3;
        return e;
    endfunction

    function automatic logic [8:0] ins(input logic [2:0] op, input logic [1:0] rs,
                                       input logic [1:0] rt, input logic [1:0] rd);
        return {op, rs, rt, rd};
    endfunction

    // All stimulus tasks are entered and left on a falling edge.
    task automatic load_reg(input logic [1:0] a, input logic [3:0] d);
        reg_we = 1'b1; reg_addr = a; reg_data = d;
        @(negedge clk);
        reg_we = 1'b0;
    endtask

    task automatic load_instr(input logic [3:0] a, input logic [8:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] l, input bit push, input exp_t e);
        int lc;
        lc = (l > 5'd16) ? 16 : int'(l);
        if (push) begin
            e.done_cyc = cyc + 1 + 2 * lc;
            sb.push_back(e);
        end
        start = 1'b1; len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cnt);
        bit found;
        found    = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (done === 1'b1) found = 1'b1;
            else begin
                if (busy === 1'b1) busy_cnt++;
                @(negedge clk);
            end
        end
        check("done_seen", 32'(found), 32'd1);
        @(negedge clk);
    endtask

    // Monitor: sole owner of view_addr.
    initial begin
        exp_t e;
        view_addr = 2'd0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("result", result, e.result);
                    check("pc", pc, e.pc);
                    for (int i = 0; i < 4; i++) begin
                        view_addr = 2'(i);
                        #1;
                        check($sformatf("reg%0d", i), view_data, e.regs[i]);
                    end
                    view_addr = 2'd0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int done_cnt;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        reg_we = 1'b0; reg_addr = '0; reg_data = '0; start = 1'b0; len = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pc", pc, 4'd0);
        check("rst_result", result, 4'd0);
        check("rst_view", view_data, 4'd0);
        start_run(5'd0, 1'b1, mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0));
        wait_done(bc);
        check("len0_busy_cycles", bc, 0);

        // ADD / SUB
        load_reg(2'd0, 4'd6);
        load_reg(2'd1, 4'd3);
        load_instr(4'd0, ins(3'd1, 2'd0, 2'd1, 2'd2));
        load_instr(4'd1, ins(3'd0, 2'd0, 2'd1, 2'd3));
        start_run(5'd2, 1'b1, mk(4'd3, 4'd1, 4'd6, 4'd3, 4'd9, 4'd3));
        wait_done(bc);
        check("t1_busy_cycles", bc, 4);

        // LT, EQ, RSHIFT
        load_reg(2'd0, 4'd5);
        load_reg(2'd1, 4'd5);
        load_instr(4'd0, ins(3'd6, 2'd0, 2'd1, 2'd2));
        load_instr(4'd1, ins(3'd7, 2'd0, 2'd1, 2'd3));
        load_instr(4'd2, ins(3'd4, 2'd0, 2'd1, 2'd0));
        start_run(5'd3, 1'b1, mk(4'd2, 4'd2, 4'd2, 4'd5, 4'hA, 4'hF));
        wait_done(bc);
        check("t2_busy_cycles", bc, 6);

        // Clamp len=20 to 16, pc stops at 15
        load_reg(2'd0, 4'd15);
        load_reg(2'd1, 4'd1);
        for (int i = 0; i < 16; i++) load_instr(4'(i), ins(3'd1, 2'd0, 2'd1, 2'd0));
        start_run(5'd20, 1'b1, mk(4'd15, 4'd15, 4'd15, 4'd1, 4'hA, 4'hF));
        wait_done(bc);
        check("t3_busy_cycles", bc, 32);

        // Aliasing: rd == rs / rt
        load_reg(2'd0, 4'd9);
        load_instr(4'd0, ins(3'd5, 2'd0, 2'd0, 2'd0));
        load_instr(4'd1, ins(3'd3, 2'd0, 2'd0, 2'd1));
        start_run(5'd2, 1'b1, mk(4'd3, 4'd1, 4'd3, 4'd3, 4'hA, 4'hF));
        wait_done(bc);

        // Writes and start during a run must be ignored
        start_run(5'd2, 1'b1, mk(4'd6, 4'd1, 4'd6, 4'd6, 4'hA, 4'hF));
        start = 1'b1; len = 5'd3;
        reg_we = 1'b1; reg_addr = 2'd0; reg_data = 4'hF;
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = ins(3'd2, 2'd0, 2'd1, 2'd2);
        @(negedge clk);
        start = 1'b0; reg_we = 1'b0; prog_we = 1'b0;
        wait_done(bc);
        start_run(5'd0, 1'b1, mk(4'd6, 4'd0, 4'd6, 4'd6, 4'hA, 4'hF));
        wait_done(bc);
        check("t5_len0_busy_cycles", bc, 0);

        // Reset in the second EXEC of a 4-instruction run
        start_run(5'd4, 1'b0, mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pc", pc, 4'd0);
        check("mid_rst_result", result, 4'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("mid_rst_done_pulses", done_cnt, 0);
        start_run(5'd0, 1'b1, mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0));
        wait_done(bc);

        // Fresh run after the reset
        load_reg(2'd0, 4'd6);
        load_reg(2'd1, 4'd3);
        load_instr(4'd0, ins(3'd1, 2'd0, 2'd1, 2'd2));
        start_run(5'd1, 1'b1, mk(4'd9, 4'd0, 4'd6, 4'd3, 4'd9, 4'd0));
        wait_done(bc);
        check("fresh_busy_cycles", bc, 2);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
